// File: rtl/if_id_skid_pkg.sv
// Shared definitions for the IF/ID skid stage: hold-flag encodings,
// the default bubble instruction and the occupancy state enum.
package if_id_skid_pkg;

   localparam logic [1:0] HOLD_RUN   = 2'b00;
   localparam logic [1:0] HOLD_FLUSH = 2'b01;
   localparam logic [1:0] HOLD_STALL = 2'b10;

   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_state_t;

endpackage

// File: rtl/if_id_skid_pipe_entry_reg.sv
// Generic pipeline entry register: async active-low reset to a set value,
// otherwise loads d when load is high.
module pipe_entry_reg #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with a two-entry skid buffer (main drives ID, skid
// absorbs one extra instruction while ID back-pressures).
module if_id_skid
   import if_id_skid_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        hold_flag_i,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [ADDR_W-1:0] inst_addr_i,
   input  logic [INST_W-1:0] inst_i,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic [INST_W-1:0] inst_o
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [INST_W-1:0] inst;
   } entry_t;

   localparam entry_t ENTRY_CLR = '{valid: 1'b0, addr: '0, inst: NOP_INST};

   occ_state_t state, state_nxt;
   entry_t     main_q, skid_q, main_d, skid_d, entry_in;
   logic       main_ld, skid_ld;
   logic       run, flush, accept, emit;

   // hold_flag 2'b11 shares the flush encoding bit, so it flushes too.
   assign run   = (hold_flag_i == HOLD_RUN);
   assign flush = hold_flag_i[0];

   assign if_ready_o = (state != OCC_FULL) && run;
   assign id_valid_o = main_q.valid && run;
   assign accept     = if_valid_i && if_ready_o;
   assign emit       = id_valid_o && id_ready_i;

   assign inst_addr_o = id_valid_o ? main_q.addr : '0;
   assign inst_o      = id_valid_o ? main_q.inst : NOP_INST;

   assign entry_in = '{valid: 1'b1, addr: inst_addr_i, inst: inst_i};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      main_ld   = 1'b0;
      main_d    = ENTRY_CLR;
      skid_ld   = 1'b0;
      skid_d    = ENTRY_CLR;
      if (flush) begin
         state_nxt = OCC_EMPTY;
         main_ld   = 1'b1;
         skid_ld   = 1'b1;
      end else if (run) begin
         case (state)
            OCC_EMPTY: begin
               if (accept) begin
                  main_ld   = 1'b1;
                  main_d    = entry_in;
                  state_nxt = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (accept && emit) begin
                  main_ld = 1'b1;
                  main_d  = entry_in;
               end else if (accept) begin
                  skid_ld   = 1'b1;
                  skid_d    = entry_in;
                  state_nxt = OCC_FULL;
               end else if (emit) begin
                  main_ld   = 1'b1;
                  state_nxt = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (emit) begin
                  main_ld   = 1'b1;
                  main_d    = skid_q;
                  skid_ld   = 1'b1;
                  state_nxt = OCC_ONE;
               end
            end
            default: begin
               state_nxt = OCC_EMPTY;
               main_ld   = 1'b1;
               skid_ld   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= OCC_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   pipe_entry_reg #(.W($bits(entry_t)), .RST_VAL(ENTRY_CLR)) u_main (
      .clk   (clk),
      .rst_n (rst),
      .load  (main_ld),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_entry_reg #(.W($bits(entry_t)), .RST_VAL(ENTRY_CLR)) u_skid (
      .clk   (clk),
      .rst_n (rst),
      .load  (skid_ld),
      .d     (skid_d),
      .q     (skid_q)
   );

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: default-width and narrow (32/16, NOP=0x0001) instances
// share stimulus and are checked against a queue-based reference model.
module tb_if_id_skid;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  hold = 2'b00;
   logic        if_valid = 1'b0;
   logic        id_ready = 1'b0;
   logic [63:0] a_in = '0;
   logic [31:0] i_in = '0;

   logic        rdy_a, vld_a, rdy_b, vld_b;
   logic [63:0] addr_a;
   logic [31:0] inst_a;
   logic [31:0] addr_b;
   logic [15:0] inst_b;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] inst;
   } ent_t;

   ent_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   if_id_skid dut_a (
      .clk         (clk),
      .rst         (rst),
      .hold_flag_i (hold),
      .if_valid_i  (if_valid),
      .if_ready_o  (rdy_a),
      .inst_addr_i (a_in),
      .inst_i      (i_in),
      .id_valid_o  (vld_a),
      .id_ready_i  (id_ready),
      .inst_addr_o (addr_a),
      .inst_o      (inst_a)
   );

   if_id_skid #(.ADDR_W(32), .INST_W(16), .NOP_INST(16'h0001)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .hold_flag_i (hold),
      .if_valid_i  (if_valid),
      .if_ready_o  (rdy_b),
      .inst_addr_i (a_in[31:0]),
      .inst_i      (i_in[15:0]),
      .id_valid_o  (vld_b),
      .id_ready_i  (id_ready),
      .inst_addr_o (addr_b),
      .inst_o      (inst_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs follow directly from queue occupancy and the hold flag.
   task automatic compare_all(input string tag);
      logic        run, exp_rdy, exp_vld;
      logic [63:0] ea;
      logic [31:0] ei;
      logic [31:0] eab;
      logic [15:0] eib;
      run     = (hold == 2'b00);
      exp_rdy = (q.size() < 2) && run;
      exp_vld = (q.size() > 0) && run;
      ea = '0; ei = 32'h0000_0013; eab = '0; eib = 16'h0001;
      if (exp_vld) begin
         ea  = q[0].addr;
         ei  = q[0].inst;
         eab = q[0].addr[31:0];
         eib = q[0].inst[15:0];
      end
      check({tag, ".a.rdy"},  64'(rdy_a),  64'(exp_rdy));
      check({tag, ".a.vld"},  64'(vld_a),  64'(exp_vld));
      check({tag, ".a.addr"}, addr_a,      ea);
      check({tag, ".a.inst"}, 64'(inst_a), 64'(ei));
      check({tag, ".b.rdy"},  64'(rdy_b),  64'(exp_rdy));
      check({tag, ".b.vld"},  64'(vld_b),  64'(exp_vld));
      check({tag, ".b.addr"}, 64'(addr_b), 64'(eab));
      check({tag, ".b.inst"}, 64'(inst_b), 64'(eib));
   endtask

   task automatic model_step();
      logic run, acc, emt;
      run = (hold == 2'b00);
      acc = if_valid && (q.size() < 2) && run;
      emt = id_ready && (q.size() > 0) && run;
      if (hold[0]) begin
         q.delete();
      end else if (run) begin
         if (emt) void'(q.pop_front());
         if (acc) q.push_back('{addr: a_in, inst: i_in});
      end
   endtask

   task automatic cyc(input logic [1:0] h, input logic v, input logic r,
                      input logic [63:0] a, input logic [31:0] i, input string tag);
      @(negedge clk);
      hold = h; if_valid = v; id_ready = r; a_in = a; i_in = i;
      #1;
      compare_all(tag);
      model_step();
   endtask

   initial begin
      int r;
      repeat (2) @(negedge clk);
      #1;
      compare_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // Back-to-back stream, one-cycle latency
      cyc(2'b00, 1'b1, 1'b1, 64'h1000, 32'h0000_1111, "stream0");
      cyc(2'b00, 1'b1, 1'b1, 64'h1004, 32'h0000_2222, "stream1");
      cyc(2'b00, 1'b1, 1'b1, 64'h1008, 32'h0000_3333, "stream2");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "stream3");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "stream4");

      // Backpressure to FULL, then drain in order
      cyc(2'b00, 1'b1, 1'b0, 64'h2000, 32'hAAAA_0001, "bp0");
      cyc(2'b00, 1'b1, 1'b0, 64'h2004, 32'hAAAA_0002, "bp1");
      cyc(2'b00, 1'b1, 1'b0, 64'h2008, 32'hAAAA_0003, "bp_full");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "bp_drain0");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "bp_drain1");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "bp_drain2");

      // Flush from FULL with a same-cycle offered instruction
      cyc(2'b00, 1'b1, 1'b0, 64'h2FF0, 32'hBBBB_0001, "fl_fill0");
      cyc(2'b00, 1'b1, 1'b0, 64'h2FF8, 32'hBBBB_0002, "fl_fill1");
      cyc(2'b01, 1'b1, 1'b1, 64'h3000, 32'hCCCC_0000, "flush");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "post_flush0");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "post_flush1");

      // Stall with one entry held
      cyc(2'b00, 1'b1, 1'b0, 64'h4000, 32'hDDDD_4000, "st_load");
      for (int k = 0; k < 3; k++)
         cyc(2'b10, 1'b1, 1'b1, 64'h4100 + 64'(k), 32'hEEEE_0000, "stall");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "st_release");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "st_empty");

      // Async reset between edges while FULL
      cyc(2'b00, 1'b1, 1'b0, 64'h5000, 32'hFFFF_0001, "ar_fill0");
      cyc(2'b00, 1'b1, 1'b0, 64'h5004, 32'hFFFF_0002, "ar_fill1");
      cyc(2'b00, 1'b0, 1'b0, 64'h0,    32'h0,         "ar_full");
      @(negedge clk);
      #2;
      rst = 1'b0;
      q.delete();
      #1;
      compare_all("async_rst");
      @(negedge clk);
      rst = 1'b1;
      cyc(2'b00, 1'b1, 1'b1, 64'h6000, 32'h1234_5678, "ar_after0");
      cyc(2'b00, 1'b0, 1'b1, 64'h0,    32'h0,         "ar_after1");

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         logic [1:0] h;
         r = int'($urandom_range(0, 19));
         if (r < 14)      h = 2'b00;
         else if (r < 17) h = 2'b10;
         else if (r < 19) h = 2'b01;
         else             h = 2'b11;
         cyc(h, 1'($urandom), 1'($urandom), {$urandom, $urandom}, $urandom, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
